// File: rtl/mem_wb_stage.sv
// Memory/writeback stage: drives the valid/ready data-memory bus, sizes loads and stores,
// stalls on slow memory, and holds the M/W pipeline register feeding the register file.
module mem_wb_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic [1:0]  ResultSrcM,
  input  logic [2:0]  Funct3M,
  input  logic [4:0]  RD_M,
  input  logic [31:0] ALU_ResultM,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] PCPlus4M,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        stallM,
  output logic        RegWriteW,
  output logic [4:0]  RDW,
  output logic [31:0] ResultW,
  output logic        misalignW,
  output logic        timeoutW
);

  localparam int CW = $clog2(TIMEOUT + 1);

  // Bus handshake: a request completes in any cycle where dmem_req and dmem_ready are
  // both high; while waiting, dmem_req stays high and addr/wdata/be/we stay constant.
  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [1:0]  off;
  logic        is_load, memop, misaligned, mis_access, abort;
  logic [31:0] lane, load_data, result_m;

  assign off       = ALU_ResultM[1:0];
  assign is_load   = (ResultSrcM == 2'b01);
  assign memop     = MemWriteM | is_load;
  assign dmem_addr = {ALU_ResultM[31:2], 2'b00};
  assign dmem_we   = MemWriteM;
  assign mis_access = memop & misaligned;

  // Funct3M[1:0] selects the access size; the sign bit only matters for loads.
  always_comb begin
    misaligned = 1'b0;
    dmem_be    = 4'b1111;
    dmem_wdata = WriteDataM;
    case (Funct3M[1:0])
      2'b00: begin
        dmem_be    = 4'b0001 << off;
        dmem_wdata = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        misaligned = off[0];
        dmem_be    = 4'b0011 << off;
        dmem_wdata = {2{WriteDataM[15:0]}};
      end
      default: misaligned = (off != 2'b00);
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = '0;
    dmem_req = 1'b0;
    abort    = 1'b0;
    case (state_q)
      S_IDLE: begin
        dmem_req = memop & ~misaligned;
        if (dmem_req && !dmem_ready) begin
          state_d = S_BUSY;
          cnt_d   = CW'(1);
        end
      end
      S_BUSY: begin
        dmem_req = 1'b1;
        if (dmem_ready) begin
          state_d = S_IDLE;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          abort   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Reset must silence the bus even while M inputs still present a memory op.
    if (rst) begin
      dmem_req = 1'b0;
      abort    = 1'b0;
    end
    stallM = dmem_req & ~dmem_ready & ~abort;
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign lane = dmem_rdata >> {off, 3'b000};

  always_comb begin
    case (Funct3M)
      3'b000:  load_data = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_data = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_data = {24'h0, lane[7:0]};
      3'b101:  load_data = {16'h0, lane[15:0]};
      default: load_data = lane;
    endcase
  end

  always_comb begin
    case (ResultSrcM)
      2'b01:   result_m = load_data;
      2'b10:   result_m = PCPlus4M;
      default: result_m = ALU_ResultM;
    endcase
  end

  // A stalled cycle leaves a bubble in W; RDW/ResultW keep their last values.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      RegWriteW <= 1'b0;
      RDW       <= '0;
      ResultW   <= '0;
      misalignW <= 1'b0;
      timeoutW  <= 1'b0;
    end else if (stallM) begin
      RegWriteW <= 1'b0;
      misalignW <= 1'b0;
      timeoutW  <= 1'b0;
    end else begin
      RDW       <= RD_M;
      ResultW   <= result_m;
      RegWriteW <= RegWriteM & (RD_M != 5'd0) & ~mis_access & ~abort;
      misalignW <= mis_access;
      timeoutW  <= abort;
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: an instruction-level model predicts every cycle of bus,
// stall and W-stage outputs, and literal checks pin the worked examples.
module tb_mem_wb_stage;

  localparam int TO = 4;

  logic        CLK = 1'b0;
  logic        rst;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  Funct3M;
  logic [4:0]  RD_M;
  logic [31:0] ALU_ResultM, WriteDataM, PCPlus4M;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        stallM, RegWriteW;
  logic [4:0]  RDW;
  logic [31:0] ResultW;
  logic        misalignW, timeoutW;

  always #5 CLK = ~CLK;

  mem_wb_stage #(.TIMEOUT(TO)) dut (
    .CLK(CLK), .rst(rst),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .Funct3M(Funct3M), .RD_M(RD_M), .ALU_ResultM(ALU_ResultM),
    .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .stallM(stallM), .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW),
    .misalignW(misalignW), .timeoutW(timeoutW)
  );

  typedef struct packed {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        stall;
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] res;
    logic        mis;
    logic        tmo;
  } exp_t;
  localparam int EW = $bits(exp_t);
  logic [EW-1:0] exp_q[$];

  int n_vec = 0;
  int n_err = 0;

  // Expected W-stage contents as of the current cycle
  logic        m_rw, m_mis, m_tmo;
  logic [4:0]  m_rd;
  logic [31:0] m_res;

  // What the DUT showed on the bus during the most recent instruction
  int          obs_stall;
  logic        obs_req;
  logic [31:0] obs_addr, obs_wdata;
  logic [3:0]  obs_be;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_t'(exp_q.pop_front());
      check("dmem_req", {31'd0, dmem_req}, {31'd0, e.req});
      check("stallM", {31'd0, stallM}, {31'd0, e.stall});
      if (e.req) begin
        check("dmem_we", {31'd0, dmem_we}, {31'd0, e.we});
        check("dmem_addr", dmem_addr, e.addr);
        check("dmem_be", {28'd0, dmem_be}, {28'd0, e.be});
        if (e.we) check("dmem_wdata", dmem_wdata, e.wdata);
      end
      check("RegWriteW", {31'd0, RegWriteW}, {31'd0, e.rw});
      check("RDW", {27'd0, RDW}, {27'd0, e.rd});
      check("ResultW", ResultW, e.res);
      check("misalignW", {31'd0, misalignW}, {31'd0, e.mis});
      check("timeoutW", {31'd0, timeoutW}, {31'd0, e.tmo});
      if (stallM) obs_stall++;
      if (dmem_req) begin
        obs_req   = 1'b1;
        obs_addr  = dmem_addr;
        obs_wdata = dmem_wdata;
        obs_be    = dmem_be;
      end
    end
  end

  function automatic int size_bytes(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] load_value(input logic [2:0] f3, input int off,
                                             input logic [31:0] rdata);
    logic [31:0] v;
    int nb;
    nb = size_bytes(f3);
    v = '0;
    for (int i = 0; i < nb; i++)
      if (off + i < 4) v[8*i +: 8] = rdata[8*(off+i) +: 8];
    if (!f3[2] && nb < 4 && v[8*nb-1])
      for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  // One M-stage instruction; M inputs are held for as long as the stage stalls.
  // wait_n is how many cycles the memory withholds dmem_ready.
  task automatic run_op(input logic rw, input logic mw, input logic [1:0] rs,
                        input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] alu,
                        input logic [31:0] wd, input logic [31:0] pc, input logic [31:0] rdata,
                        input int wait_n);
    logic memop, mis, will_req, tmo;
    int nb, off, ncyc;
    logic [3:0] be;
    logic [31:0] wrep;
    exp_t e;
    memop    = mw | (rs == 2'b01);
    nb       = size_bytes(f3);
    off      = int'(alu[1:0]);
    mis      = memop && (off % nb != 0);
    will_req = memop && !mis;
    tmo      = will_req && (wait_n > TO);
    ncyc     = will_req ? (((wait_n > TO) ? TO : wait_n) + 1) : 1;
    be = '0;
    for (int i = 0; i < nb; i++) if (off + i < 4) be[off+i] = 1'b1;
    for (int i = 0; i < 4; i++) wrep[8*i +: 8] = wd[8*(i % nb) +: 8];

    RegWriteM = rw; MemWriteM = mw; ResultSrcM = rs; Funct3M = f3; RD_M = rd;
    ALU_ResultM = alu; WriteDataM = wd; PCPlus4M = pc;
    obs_stall = 0; obs_req = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      dmem_ready = will_req && (c == wait_n);
      dmem_rdata = rdata;
      e.req = will_req; e.we = mw; e.addr = {alu[31:2], 2'b00}; e.wdata = wrep; e.be = be;
      e.stall = (c < ncyc - 1);
      e.rw = m_rw; e.rd = m_rd; e.res = m_res; e.mis = m_mis; e.tmo = m_tmo;
      exp_q.push_back(e);
      @(posedge CLK); #1;
      if (c < ncyc - 1) begin
        m_rw = 1'b0; m_mis = 1'b0; m_tmo = 1'b0;
      end else begin
        m_rd  = rd;
        m_res = (rs == 2'b01) ? load_value(f3, off, rdata) : (rs == 2'b10) ? pc : alu;
        m_rw  = rw && (rd != 5'd0) && !mis && !tmo;
        m_mis = mis;
        m_tmo = tmo;
      end
    end
    dmem_ready = 1'b0;
  endtask

  task automatic nop();
    run_op(1'b0, 1'b0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0, 32'h0, 0);
  endtask

  task automatic model_reset();
    m_rw = 1'b0; m_mis = 1'b0; m_tmo = 1'b0; m_rd = '0; m_res = '0;
  endtask

  initial begin
    rst = 1'b1;
    RegWriteM = 0; MemWriteM = 0; ResultSrcM = 0; Funct3M = 0; RD_M = 0;
    ALU_ResultM = 0; WriteDataM = 0; PCPlus4M = 0; dmem_ready = 0; dmem_rdata = 0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check("rst_RegWriteW", {31'd0, RegWriteW}, 32'd0);
    check("rst_RDW", {27'd0, RDW}, 32'd0);
    check("rst_ResultW", ResultW, 32'd0);
    check("rst_misalignW", {31'd0, misalignW}, 32'd0);
    check("rst_timeoutW", {31'd0, timeoutW}, 32'd0);
    check("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
    check("rst_stallM", {31'd0, stallM}, 32'd0);
    rst = 1'b0;

    // ALU op writes back next cycle without touching the bus
    run_op(1, 0, 2'b00, 3'b000, 5'd5, 32'h1234, 32'h0, 32'h8, 32'h0, 0);
    check("alu_RegWriteW", {31'd0, RegWriteW}, 32'd1);
    check("alu_RDW", {27'd0, RDW}, 32'd5);
    check("alu_ResultW", ResultW, 32'h1234);
    check("alu_no_req", {31'd0, obs_req}, 32'd0);

    // LB from the top byte lane, ready immediately
    run_op(1, 0, 2'b01, 3'b000, 5'd7, 32'h103, 32'h0, 32'h0, 32'h8000_0000, 0);
    check("lb_ResultW", ResultW, 32'hFFFF_FF80);
    check("lb_addr", obs_addr, 32'h100);
    check("lb_be", {28'd0, obs_be}, 32'b1000);
    check("lb_stalls", obs_stall, 0);

    // SH to the upper half, ready after three waits
    run_op(0, 1, 2'b00, 3'b001, 5'd0, 32'h202, 32'hABCD, 32'h0, 32'h0, 3);
    check("sh_be", {28'd0, obs_be}, 32'b1100);
    check("sh_wdata", obs_wdata, 32'hABCD_ABCD);
    check("sh_stalls", obs_stall, 3);
    check("sh_RegWriteW", {31'd0, RegWriteW}, 32'd0);

    // Misaligned LW is dropped
    run_op(1, 0, 2'b01, 3'b010, 5'd9, 32'h301, 32'h0, 32'h0, 32'h0, 0);
    check("mis_pulse", {31'd0, misalignW}, 32'd1);
    check("mis_RegWriteW", {31'd0, RegWriteW}, 32'd0);
    check("mis_no_req", {31'd0, obs_req}, 32'd0);

    // LW that never gets ready times out
    run_op(1, 0, 2'b01, 3'b010, 5'd10, 32'h300, 32'h0, 32'h0, 32'h0, 99);
    check("tmo_stalls", obs_stall, TO);
    check("tmo_pulse", {31'd0, timeoutW}, 32'd1);
    check("tmo_RegWriteW", {31'd0, RegWriteW}, 32'd0);

    // Back in IDLE: a ready-now LW completes with no stall
    run_op(1, 0, 2'b01, 3'b010, 5'd11, 32'h304, 32'h0, 32'h0, 32'hCAFE_F00D, 0);
    check("idle_stalls", obs_stall, 0);
    check("idle_ResultW", ResultW, 32'hCAFE_F00D);

    // Ready arriving exactly when the counter reaches TIMEOUT still completes
    run_op(1, 0, 2'b01, 3'b010, 5'd12, 32'h308, 32'h0, 32'h0, 32'h1357_9BDF, TO);
    check("edge_stalls", obs_stall, TO);
    check("edge_timeoutW", {31'd0, timeoutW}, 32'd0);
    check("edge_ResultW", ResultW, 32'h1357_9BDF);

    // Halfword/byte sign handling, PC+4, reserved select, rd=0
    run_op(1, 0, 2'b01, 3'b101, 5'd13, 32'h102, 32'h0, 32'h0, 32'h8001_0000, 1);
    check("lhu_ResultW", ResultW, 32'h0000_8001);
    run_op(1, 0, 2'b01, 3'b001, 5'd14, 32'h102, 32'h0, 32'h0, 32'h8001_0000, 0);
    check("lh_ResultW", ResultW, 32'hFFFF_8001);
    run_op(1, 0, 2'b01, 3'b100, 5'd15, 32'h101, 32'h0, 32'h0, 32'h0000_F000, 2);
    check("lbu_ResultW", ResultW, 32'h0000_00F0);
    run_op(1, 0, 2'b10, 3'b000, 5'd1, 32'h55, 32'h0, 32'h0000_4004, 32'h0, 0);
    check("jal_ResultW", ResultW, 32'h0000_4004);
    run_op(1, 0, 2'b11, 3'b000, 5'd2, 32'h77, 32'h0, 32'h9, 32'h0, 0);
    check("rsv_ResultW", ResultW, 32'h77);
    run_op(1, 0, 2'b00, 3'b000, 5'd0, 32'h99, 32'h0, 32'h0, 32'h0, 0);
    check("x0_RegWriteW", {31'd0, RegWriteW}, 32'd0);
    run_op(0, 1, 2'b00, 3'b000, 5'd0, 32'h3, 32'h12, 32'h0, 32'h0, 1);
    check("sb_be", {28'd0, obs_be}, 32'b1000);
    check("sb_wdata", obs_wdata, 32'h1212_1212);
    run_op(0, 1, 2'b00, 3'b010, 5'd0, 32'h40, 32'hDEAD_BEEF, 32'h0, 32'h0, 2);
    check("sw_wdata", obs_wdata, 32'hDEAD_BEEF);
    nop();

    // Reset while BUSY: bus and stall drop before the next edge
    RegWriteM = 1; MemWriteM = 0; ResultSrcM = 2'b01; Funct3M = 3'b010; RD_M = 5'd20;
    ALU_ResultM = 32'h400; dmem_ready = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check("busy_req", {31'd0, dmem_req}, 32'd1);
    check("busy_stall", {31'd0, stallM}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_req", {31'd0, dmem_req}, 32'd0);
    check("mid_rst_stall", {31'd0, stallM}, 32'd0);
    check("mid_rst_RDW", {27'd0, RDW}, 32'd0);
    check("mid_rst_ResultW", ResultW, 32'd0);
    check("mid_rst_flags", {29'd0, RegWriteW, misalignW, timeoutW}, 32'd0);
    @(posedge CLK); #1;
    rst = 1'b0;
    model_reset();

    // After reset the FSM accepts an immediately-ready load
    run_op(1, 0, 2'b01, 3'b010, 5'd21, 32'h400, 32'h0, 32'h0, 32'h0BAD_CAFE, 0);
    check("post_rst_ResultW", ResultW, 32'h0BAD_CAFE);
    check("post_rst_stalls", obs_stall, 0);
    nop();
    @(posedge CLK); #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
